// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the 8N1 receive UART.
// The consumer drives rx_i/rd_en_i and observes the FIFO and error flags.
interface uart_rx_if;
  logic       rx_i;
  logic       rd_en_i;
  logic [7:0] data_o;
  logic       fifo_full_o;
  logic       fifo_empty_o;
  logic       frame_err_o;
  logic       overrun_o;

  modport master (
    output rx_i,
    output rd_en_i,
    input  data_o,
    input  fifo_full_o,
    input  fifo_empty_o,
    input  frame_err_o,
    input  overrun_o
  );

  modport slave (
    input  rx_i,
    input  rd_en_i,
    output data_o,
    output fifo_full_o,
    output fifo_empty_o,
    output frame_err_o,
    output overrun_o
  );
endinterface

// File: rtl/uart_rx.sv
// Receive-only 8N1 UART: 16x oversampling, 3-sample majority vote,
// stop-bit check and a byte FIFO for the downstream consumer.
module uart_rx #(
  parameter int CLK_FREQ       = 3_686_400,
  parameter int BAUD           = 115_200,
  parameter int FIFO_ADDR_BITS = 3
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int DIV   = CLK_FREQ / (16 * BAUD);
  localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int A     = FIFO_ADDR_BITS;
  localparam int DEPTH = 2 ** A;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [1:0]    sync;
  logic          rx_s;

  state_t     state, state_n;
  logic [3:0] tick_cnt, tick_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shreg, sh_n;
  logic [1:0] votes, vote_n;
  logic       wr_en, ferr_n, ovr_n;
  logic       frame_err, overrun;

  logic [7:0] mem [DEPTH];
  logic [A-1:0] wr_ptr, rd_ptr;
  logic [A:0]   count;
  logic [7:0]   data_q;
  logic         full, empty, do_wr, do_rd;

  assign tick = (div_cnt == DW'(DIV - 1));
  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      sync    <= 2'b11;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      sync    <= {sync[0], bus.rx_i};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      votes     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shreg     <= sh_n;
      votes     <= vote_n;
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    vote_n  = votes;
    wr_en   = 1'b0;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick && !rx_s) begin
          tick_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt == 4'd7) begin
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              bit_n   = '0;
              tick_n  = '0;
              vote_n  = '0;
              state_n = DATA;
            end
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt inside {4'd7, 4'd8, 4'd9} && rx_s)
            vote_n = votes + 2'd1;
          // two or more high samples out of three set votes[1]
          if (tick_cnt == 4'd15) begin
            sh_n   = {votes[1], shreg[7:1]};
            vote_n = '0;
            bit_n  = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state_n = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt == 4'd7) begin
            if (rx_s) begin
              if (full)
                ovr_n = 1'b1;
              else
                wr_en = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = BRK;
            end
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
      end
      BRK: begin
        if (rx_s)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign full  = (count == (A+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = bus.rd_en_i && !empty;

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data_q <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= mem[rd_ptr];
      end
      count <= count + (A+1)'(do_wr) - (A+1)'(do_rd);
    end
  end

  assign bus.data_o       = data_q;
  assign bus.fifo_full_o  = full;
  assign bus.fifo_empty_o = empty;
  assign bus.frame_err_o  = frame_err;
  assign bus.overrun_o    = overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives 8N1 frames on the line and
// checks popped bytes and error pulses against a queue-based model.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ      (3_686_400),
    .BAUD          (115_200),
    .FIFO_ADDR_BITS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  localparam int BIT = 32;
  localparam int DEPTH = 8;

  int errors = 0;
  int checks = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int both_cnt = 0;
  int exp_ferr = 0;
  int exp_ovr = 0;
  logic [7:0] model_q[$];
  logic [7:0] last_data = 8'h00;

  always @(negedge clk) begin
    if (bus.frame_err_o === 1'b1) ferr_cnt++;
    if (bus.overrun_o === 1'b1) ovr_cnt++;
    if (bus.frame_err_o === 1'b1 && bus.overrun_o === 1'b1) both_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // line-level frame; a glitch of one clk inverts each data bit at offset goff
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int goff);
    bus.rx_i = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      bus.rx_i = d[i];
      if (goff > 0) begin
        wait_clk(goff);
        bus.rx_i = ~d[i];
        wait_clk(1);
        bus.rx_i = d[i];
        wait_clk(BIT - 1 - goff);
      end else begin
        wait_clk(BIT);
      end
    end
    bus.rx_i = stop_bit;
    wait_clk(BIT);
  endtask

  // good frame plus model update: buffered if room, otherwise an overrun
  task automatic send_good(input logic [7:0] d);
    send_frame(d, 1'b1, 0);
    if (model_q.size() < DEPTH) model_q.push_back(d);
    else exp_ovr++;
  endtask

  task automatic pop_expect(input string name);
    logic [7:0] exp;
    exp = model_q.pop_front();
    bus.rd_en_i = 1'b1;
    wait_clk(1);
    bus.rd_en_i = 1'b0;
    checks++;
    if (bus.data_o !== exp) begin
      errors++;
      $display("FAIL %s: data_o=%h expected %h", name, bus.data_o, exp);
    end
    last_data = exp;
  endtask

  task automatic check_pulses(input string name);
    wait_clk(4);
    checks++;
    if (ferr_cnt !== exp_ferr || ovr_cnt !== exp_ovr) begin
      errors++;
      $display("FAIL %s pulses: frame_err=%0d overrun=%0d expected %0d %0d",
               name, ferr_cnt, ovr_cnt, exp_ferr, exp_ovr);
    end
  endtask

  task automatic check_empty(input string name, input logic exp);
    checks++;
    if (bus.fifo_empty_o !== exp) begin
      errors++;
      $display("FAIL %s empty: got %b expected %b", name, bus.fifo_empty_o, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.fifo_empty_o !== 1'b1 || bus.fifo_full_o !== 1'b0 ||
        bus.frame_err_o !== 1'b0 || bus.overrun_o !== 1'b0 ||
        bus.data_o !== 8'h00) begin
      errors++;
      $display("FAIL %s: empty=%b full=%b ferr=%b ovr=%b data=%h expected 1 0 0 0 00",
               name, bus.fifo_empty_o, bus.fifo_full_o, bus.frame_err_o,
               bus.overrun_o, bus.data_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.rx_i = 1'b1;
    bus.rd_en_i = 1'b0;
    wait_clk(5);
    check_reset_outputs("reset");
    rst = 1'b1;
    wait_clk(BIT);
    check_reset_outputs("after_reset");
  endtask

  task automatic test_single();
    int n;
    n = 0;
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        while (bus.fifo_empty_o === 1'b1 && n < 400) begin
          wait_clk(1);
          n++;
        end
      end
    join
    model_q.push_back(8'hA5);
    checks++;
    if (n < 2 + 9 * BIT - 10 || n > 2 + 10 * BIT) begin
      errors++;
      $display("FAIL single latency: %0d clk expected about %0d", n, 2 + 9 * BIT + BIT / 2);
    end
    pop_expect("single_A5");
    check_empty("single", 1'b1);
    check_pulses("single");
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    send_good(8'h00);
    send_good(8'hFF);
    send_good(8'h55);
    pop_expect("b2b_00");
    pop_expect("b2b_FF");
    pop_expect("b2b_55");
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      send_good(d);
    end
    for (int i = 0; i < 4; i++) pop_expect("b2b_rand");
    check_empty("b2b", 1'b1);
    check_pulses("b2b");
  endtask

  task automatic test_glitch();
    bus.rx_i = 1'b0;
    wait_clk(8);
    bus.rx_i = 1'b1;
    wait_clk(2 * BIT);
    check_empty("glitch", 1'b1);
    bus.rd_en_i = 1'b1;
    wait_clk(1);
    bus.rd_en_i = 1'b0;
    wait_clk(1);
    checks++;
    if (bus.data_o !== last_data || bus.fifo_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL pop_empty: data_o=%h empty=%b expected %h 1",
               bus.data_o, bus.fifo_empty_o, last_data);
    end
    check_pulses("glitch");
  endtask

  task automatic test_break();
    send_frame(8'h3C, 1'b0, 0);
    exp_ferr++;
    wait_clk(3 * BIT);
    bus.rx_i = 1'b1;
    wait_clk(BIT);
    check_empty("break", 1'b1);
    check_pulses("break");
    send_good(8'h81);
    pop_expect("break_81");
    check_pulses("break_after");
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 9; i++) begin
      send_good(8'(i));
      if (i == 8) begin
        checks++;
        if (bus.fifo_full_o !== 1'b1) begin
          errors++;
          $display("FAIL full_after_8: fifo_full_o=%b expected 1", bus.fifo_full_o);
        end
      end
    end
    check_pulses("overrun");
    for (int i = 1; i <= 8; i++) pop_expect("overrun_pop");
    check_empty("overrun", 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h77;
    bus.rx_i = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 3; i++) begin
      bus.rx_i = d[i];
      wait_clk(BIT);
    end
    rst = 1'b0;
    #2;
    check_reset_outputs("reset_mid");
    bus.rx_i = 1'b1;
    model_q.delete();
    last_data = 8'h00;
    wait_clk(BIT);
    rst = 1'b1;
    wait_clk(3 * BIT);
    check_reset_outputs("reset_mid_release");
    send_good(8'h12);
    pop_expect("reset_mid_12");
    check_pulses("reset_mid");
  endtask

  task automatic test_majority();
    send_frame(8'h96, 1'b1, 2);
    model_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 3);
    model_q.push_back(8'h96);
    pop_expect("majority_a");
    pop_expect("majority_b");
    check_pulses("majority");
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      send_good(d);
      if ($urandom_range(0, 2) == 0 && model_q.size() > 0)
        pop_expect("random_pop");
    end
    check_pulses("random");
    while (model_q.size() > 0) pop_expect("random_drain");
    check_empty("random", 1'b1);
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL both_pulses: %0d cycles with frame_err and overrun", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
    test_majority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
